// File: rtl/fetch_unit.sv
// fetch_unit: PC / IR datapath stage. Holds the program counter and the
// instruction register, computes sequential / branch / jump next-PC, steers
// the shared memory address port and counts PC-changing events.
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int unsigned ADDR_BITS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pc_en,
   input  logic        pc_mux,
   input  logic        j_en,
   input  logic        ir_en,
   input  logic        ls_ctrl,
   input  logic [15:0] mem_rdata,
   input  logic [15:0] jump_target,
   input  logic [15:0] ls_addr,
   output logic [15:0] mem_addr,
   output logic [15:0] opcode,
   output logic [15:0] pc,
   output logic [15:0] link_addr,
   output logic [15:0] retired
);

   // Bits above ADDR_BITS are forced to zero; masking after each add gives
   // modulo-2^ADDR_BITS wrap.
   localparam logic [31:0] MASK32 = (32'h1 << ADDR_BITS) - 32'h1;
   localparam logic [15:0] MASK   = MASK32[15:0];

   logic [15:0] pc_q;
   logic [15:0] ir_q;
   logic [15:0] ret_q;
   logic [15:0] pc_seq;
   logic [15:0] pc_br;
   logic [15:0] pc_next;

   // Next-PC selection: jump beats branch/sequential, otherwise hold.
   always_comb begin
      pc_seq  = (pc_q + 16'd1) & MASK;
      pc_br   = (pc_q + {{8{ir_q[7]}}, ir_q[7:0]}) & MASK;
      pc_next = pc_q;
      if (j_en) begin
         pc_next = jump_target & MASK;
      end else if (pc_en) begin
         pc_next = pc_mux ? pc_br : pc_seq;
      end
   end

   // PC, IR and retired-event counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_PC & MASK;
         ir_q  <= '0;
         ret_q <= '0;
      end else begin
         pc_q <= pc_next;
         if (ir_en) begin
            ir_q <= mem_rdata;
         end
         if (j_en || pc_en) begin
            ret_q <= ret_q + 16'd1;
         end
      end
   end

   // Address steering and register-derived outputs.
   always_comb begin
      mem_addr  = ls_ctrl ? ls_addr : pc_q;
      link_addr = pc_seq;
      opcode    = ir_q;
      pc        = pc_q;
      retired   = ret_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// behavioural model; a full-width and an 8-bit-address instance share stimulus.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        pc_en, pc_mux, j_en, ir_en, ls_ctrl;
   logic [15:0] mem_rdata, jump_target, ls_addr;
   logic [15:0] mem_addr [2];
   logic [15:0] opcode   [2];
   logic [15:0] pc       [2];
   logic [15:0] link_addr[2];
   logic [15:0] retired  [2];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Model state: one PC per instance, shared IR and counter.
   int          pc_m [2];
   int          addr_bits [2] = '{16, 8};
   logic [15:0] ir_m;
   int          ret_m;

   always #5 clock = ~clock;

   fetch_unit #(.RESET_PC(16'h0000), .ADDR_BITS(16)) u_dut16 (
      .clock(clock), .reset(reset), .pc_en(pc_en), .pc_mux(pc_mux),
      .j_en(j_en), .ir_en(ir_en), .ls_ctrl(ls_ctrl), .mem_rdata(mem_rdata),
      .jump_target(jump_target), .ls_addr(ls_addr), .mem_addr(mem_addr[0]),
      .opcode(opcode[0]), .pc(pc[0]), .link_addr(link_addr[0]), .retired(retired[0])
   );

   fetch_unit #(.RESET_PC(16'h0000), .ADDR_BITS(8)) u_dut8 (
      .clock(clock), .reset(reset), .pc_en(pc_en), .pc_mux(pc_mux),
      .j_en(j_en), .ir_en(ir_en), .ls_ctrl(ls_ctrl), .mem_rdata(mem_rdata),
      .jump_target(jump_target), .ls_addr(ls_addr), .mem_addr(mem_addr[1]),
      .opcode(opcode[1]), .pc(pc[1]), .link_addr(link_addr[1]), .retired(retired[1])
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic int wrap(input int v, input int bits);
      int size;
      size = 1 << bits;
      return ((v % size) + size) % size;
   endfunction

   task automatic model_reset();
      pc_m[0] = 0;
      pc_m[1] = 0;
      ir_m    = 16'h0000;
      ret_m   = 0;
   endtask

   // Apply the rules for one rising edge using the pre-edge inputs.
   task automatic model_edge();
      int disp;
      if (!reset) begin
         model_reset();
      end else begin
         disp = pc_mux ? int'($signed(ir_m[7:0])) : 1;
         for (int d = 0; d < 2; d++) begin
            if (j_en)        pc_m[d] = wrap(int'(jump_target), addr_bits[d]);
            else if (pc_en)  pc_m[d] = wrap(pc_m[d] + disp, addr_bits[d]);
         end
         if (ir_en) ir_m = mem_rdata;
         if (j_en || pc_en) ret_m = (ret_m + 1) % 65536;
      end
   endtask

   task automatic check_all(input string tag);
      for (int d = 0; d < 2; d++) begin
         string s;
         s = $sformatf("%s[%0d]", tag, d);
         check({s, ".pc"},        pc[d],        16'(pc_m[d]));
         check({s, ".opcode"},    opcode[d],    ir_m);
         check({s, ".retired"},   retired[d],   16'(ret_m));
         check({s, ".link_addr"}, link_addr[d], 16'(wrap(pc_m[d] + 1, addr_bits[d])));
         check({s, ".mem_addr"},  mem_addr[d],  ls_ctrl ? ls_addr : 16'(pc_m[d]));
      end
   endtask

   task automatic idle_inputs();
      pc_en = 0; pc_mux = 0; j_en = 0; ir_en = 0; ls_ctrl = 0;
   endtask

   // One clock edge; inputs are changed by the caller 1 time unit after it.
   task automatic step(input string tag, input bit do_check);
      @(posedge clock);
      model_edge();
      #1;
      if (do_check) check_all(tag);
   endtask

   initial begin
      idle_inputs();
      mem_rdata = 16'h0; jump_target = 16'h0; ls_addr = 16'h0;
      reset = 1'b0;
      model_reset();
      #2;
      check_all("reset_init");
      step("reset_hold", 1);
      reset = 1'b1;
      step("idle_after_reset", 1);

      // Asynchronous reset mid-cycle from PC=0x0042 with a loaded IR.
      j_en = 1; jump_target = 16'h0042; ir_en = 1; mem_rdata = 16'h1234;
      step("setup_42", 1);
      idle_inputs();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      pc_en = 1; j_en = 1; ir_en = 1; jump_target = 16'h0777;
      step("enables_in_reset", 1);
      #2;
      reset = 1'b1;
      idle_inputs();
      step("hold_after_release_a", 1);
      step("hold_after_release_b", 1);

      // Sequential increment x3.
      pc_en = 1;
      for (int i = 0; i < 3; i++) step("seq", 1);
      idle_inputs();
      check("seq.pc3", pc[0], 16'h0003);
      check("seq.link4", link_addr[0], 16'h0004);
      check("seq.ret3", retired[0], 16'h0003);

      // Branches: negative, positive, wrap across the top of the space.
      begin
         logic [15:0] pcs [3] = '{16'h0010, 16'h0010, 16'hFFFF};
         logic [15:0] irs [3] = '{16'hC0FE, 16'hC07F, 16'h0001};
         logic [15:0] exp [3] = '{16'h000E, 16'h008F, 16'h0000};
         for (int i = 0; i < 3; i++) begin
            j_en = 1; jump_target = pcs[i]; ir_en = 1; mem_rdata = irs[i];
            step("br_setup", 1);
            idle_inputs();
            pc_en = 1; pc_mux = 1;
            step("branch", 1);
            idle_inputs();
            check("branch.pc_const", pc[0], exp[i]);
         end
      end

      // Jump beats pc_en; counter moves by one only.
      begin
         int r0;
         r0 = ret_m;
         j_en = 1; pc_en = 1; pc_mux = 1; jump_target = 16'h1234;
         step("jump_prio", 1);
         idle_inputs();
         check("jump.pc16", pc[0], 16'h1234);
         check("jump.pc8", pc[1], 16'h0034);
         check("jump.ret", retired[0], 16'(r0 + 1));
      end

      // IR latch and hold.
      ir_en = 1; mem_rdata = 16'h4C05;
      step("ir_load", 1);
      idle_inputs();
      check("ir.opcode", opcode[0], 16'h4C05);
      check("ir.pc_same", pc[0], 16'h1234);
      mem_rdata = 16'hDEAD;
      step("ir_hold", 1);

      // Address mux.
      ls_ctrl = 1; ls_addr = 16'hBEEF;
      #1;
      check("mux.ls", mem_addr[1], 16'hBEEF);
      check_all("mux_ls");
      ls_ctrl = 0;
      #1;
      check_all("mux_pc");

      // Counter wrap: 65535 pulses from reset, then one more.
      reset = 1'b0;
      model_reset();
      #1;
      reset = 1'b1;
      pc_en = 1;
      for (int i = 0; i < 65535; i++) step("wrap_fill", 0);
      check_all("wrap_ffff");
      check("wrap.ffff", retired[0], 16'hFFFF);
      step("wrap_zero", 1);
      check("wrap.zero", retired[0], 16'h0000);
      idle_inputs();

      // Randomized mix of all enables.
      for (int i = 0; i < 400; i++) begin
         pc_en       = 1'($urandom_range(0, 1));
         pc_mux      = 1'($urandom_range(0, 1));
         j_en        = ($urandom_range(0, 5) == 0);
         ir_en       = 1'($urandom_range(0, 1));
         ls_ctrl     = 1'($urandom_range(0, 1));
         mem_rdata   = 16'($urandom);
         jump_target = 16'($urandom);
         ls_addr     = 16'($urandom);
         #1;
         check_all("rand_comb");
         step("rand", 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
